// File: rtl/lfsr_pkg.sv
// Shared constants and next-state helper for the Fibonacci LFSR generator.
// Bit i of a tap mask selects state[i] into the feedback XOR.
package lfsr_pkg;

    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    // Operates on a 32-bit container; callers zero-extend and truncate to their width.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps);
        return {state[30:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Measures the LFSR cycle length relative to a reference seed.
// Emits a wrap pulse when a step lands back on the reference.
module lfsr_period_meter
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_i,
    input  logic [WIDTH-1:0] next_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             wrap_o,
    output logic [WIDTH-1:0] period_o
);

    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        if (load_i) begin
            ref_d = load_data_i;
            cnt_d = '0;
        end else if (step_i) begin
            if (next_i == ref_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_q    <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
        end
    end

    assign wrap_o   = wrap_q;
    assign period_o = period_q;

endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with step enable, handshaked seed loading and period measurement.
// All outputs are registered.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed_data,
    output logic             seed_ready,
    output logic             load_err,
    output logic [WIDTH-1:0] lfsr_o,
    output logic             out_valid,
    output logic             wrap,
    output logic [WIDTH-1:0] period_o
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic             seed_ready_q, seed_ready_d;
    logic             load_err_q, load_err_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] next_state;
    logic             seed_req;
    logic             load_fire;
    logic             step_fire;

    assign next_state = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS)));

    // A zero seed is rejected without stalling the step path.
    assign seed_req  = seed_valid & seed_ready_q;
    assign load_fire = seed_req & (seed_data != '0);
    assign step_fire = en & ~load_fire;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = 1'b0;
        load_err_d   = seed_req & (seed_data == '0);
        seed_ready_d = ~load_fire;
        if (load_fire) begin
            state_d     = seed_data;
            out_valid_d = 1'b1;
        end else if (step_fire) begin
            state_d     = next_state;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEED;
            seed_ready_q <= 1'b1;
            load_err_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_ready_q <= seed_ready_d;
            load_err_q   <= load_err_d;
            out_valid_q  <= out_valid_d;
        end
    end

    lfsr_period_meter #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_meter (
        .clk         (clk),
        .reset       (reset),
        .step_i      (step_fire),
        .next_i      (next_state),
        .load_i      (load_fire),
        .load_data_i (seed_data),
        .wrap_o      (wrap),
        .period_o    (period_o)
    );

    assign lfsr_o     = state_q;
    assign seed_ready = seed_ready_q;
    assign load_err   = load_err_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 8-bit default instance plus two 4-bit tap variants.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit default instance
    logic       reset, en, seed_valid;
    logic [7:0] seed_data;
    logic       seed_ready, load_err, out_valid, wrap;
    logic [7:0] lfsr, period;

    // 4-bit instances share stimulus
    logic       reset4, en4, sv4;
    logic [3:0] sd4;
    logic       rdy_c, err_c, val_c, wrap_c, rdy_a, err_a, val_a, wrap_a;
    logic [3:0] lfsr_c, period_c, lfsr_a, period_a;

    int n_cmp = 0;
    int n_bad = 0;
    bit nz_on = 1'b0;

    lfsr_gen u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .load_err   (load_err),
        .lfsr_o     (lfsr),
        .out_valid  (out_valid),
        .wrap       (wrap),
        .period_o   (period)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) u_dut4c (
        .clk        (clk),
        .reset      (reset4),
        .en         (en4),
        .seed_valid (sv4),
        .seed_data  (sd4),
        .seed_ready (rdy_c),
        .load_err   (err_c),
        .lfsr_o     (lfsr_c),
        .out_valid  (val_c),
        .wrap       (wrap_c),
        .period_o   (period_c)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'hA), .SEED(4'h1)) u_dut4a (
        .clk        (clk),
        .reset      (reset4),
        .en         (en4),
        .seed_valid (sv4),
        .seed_data  (sd4),
        .seed_ready (rdy_a),
        .load_err   (err_a),
        .lfsr_o     (lfsr_a),
        .out_valid  (val_a),
        .wrap       (wrap_a),
        .period_o   (period_a)
    );

    typedef struct {
        logic       en;
        logic       sv;
        logic [7:0] sd;
        logic [7:0] lfsr;
        logic       valid;
        logic       ready;
        logic       err;
        logic       wrap;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int i);
        en         = tbl[i].en;
        seed_valid = tbl[i].sv;
        seed_data  = tbl[i].sd;
        tick();
        check($sformatf("vec%0d lfsr", i), 32'(lfsr), 32'(tbl[i].lfsr));
        check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].valid));
        check($sformatf("vec%0d seed_ready", i), 32'(seed_ready), 32'(tbl[i].ready));
        check($sformatf("vec%0d load_err", i), 32'(load_err), 32'(tbl[i].err));
        check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(tbl[i].wrap));
        en         = 1'b0;
        seed_valid = 1'b0;
    endtask

    // Steps until the first wrap pulse; returns the bound if it never comes.
    task automatic run_to_wrap(output int steps);
        en         = 1'b1;
        seed_valid = 1'b0;
        steps      = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            steps++;
            if (wrap) break;
        end
        en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (nz_on) begin
            n_cmp++;
            if (lfsr == 8'h00) begin
                n_bad++;
                $display("FAIL lfsr_nonzero: got 0x%0h, want nonzero", lfsr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int fw_c, fw_a;
        logic [3:0] exp_c[4];
        logic [3:0] exp_a[6];

        //            en    sv    sd     lfsr   valid ready err   wrap
        tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'h00, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0};
        // load beats en; next cycle seed_ready=0 blocks the second request
        tbl[5] = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'h3C, 8'h4A, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 8'h00, 8'h95, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 8'h95, 1'b0, 1'b1, 1'b0, 1'b0};

        exp_c = '{4'h2, 4'h4, 4'h9, 4'h3};
        exp_a = '{4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h1};

        reset = 1'b1; en = 1'b0; seed_valid = 1'b0; seed_data = 8'h00;
        reset4 = 1'b1; en4 = 1'b0; sv4 = 1'b0; sd4 = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        nz_on = 1'b1;
        check("rst lfsr", 32'(lfsr), 32'h01);
        check("rst period", 32'(period), 32'h0);
        check("rst wrap", 32'(wrap), 32'h0);
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst seed_ready", 32'(seed_ready), 32'h1);
        check("rst load_err", 32'(load_err), 32'h0);

        // Free run from reset: 4 steps in the table, rest until wrap
        for (int i = 0; i <= 4; i++) apply_vec(i);
        run_to_wrap(s);
        check("seed wrap steps", 32'(s + 4), 32'd255);
        check("seed wrap lfsr", 32'(lfsr), 32'h01);
        check("seed wrap period", 32'(period), 32'd255);
        tick();
        check("wrap one-cycle", 32'(wrap), 32'h0);

        // Seed load, blocked request, zero-seed reject
        for (int i = 5; i <= 8; i++) apply_vec(i);
        check("period held on load", 32'(period), 32'd255);
        run_to_wrap(s);
        check("A5 wrap steps", 32'(s + 2), 32'd255);
        check("A5 wrap lfsr", 32'(lfsr), 32'hA5);
        check("A5 wrap period", 32'(period), 32'd255);

        // Reset mid-run with a competing load request
        en = 1'b1;
        repeat (100) tick();
        reset = 1'b1; seed_valid = 1'b1; seed_data = 8'h5A;
        tick();
        reset = 1'b0; seed_valid = 1'b0; en = 1'b0;
        check("midrst lfsr", 32'(lfsr), 32'h01);
        check("midrst period", 32'(period), 32'h0);
        check("midrst wrap", 32'(wrap), 32'h0);
        check("midrst out_valid", 32'(out_valid), 32'h0);
        check("midrst seed_ready", 32'(seed_ready), 32'h1);
        run_to_wrap(s);
        check("midrst wrap steps", 32'(s), 32'd255);
        check("midrst wrap lfsr", 32'(lfsr), 32'h01);

        // 4-bit variants: maximal (4'hC) and short-cycle (4'hA)
        reset4 = 1'b0;
        check("w4c rst lfsr", 32'(lfsr_c), 32'h1);
        check("w4a rst period", 32'(period_a), 32'h0);
        fw_c = 0;
        fw_a = 0;
        en4 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k < 4) check($sformatf("w4c step%0d", k + 1), 32'(lfsr_c), 32'(exp_c[k]));
            if (k < 6) check($sformatf("w4a step%0d", k + 1), 32'(lfsr_a), 32'(exp_a[k]));
            if (wrap_c && fw_c == 0) fw_c = k + 1;
            if (wrap_a && fw_a == 0) fw_a = k + 1;
        end
        en4 = 1'b0;
        check("w4c wrap step", 32'(fw_c), 32'd15);
        check("w4c wrap lfsr", 32'(lfsr_c), 32'h1);
        check("w4c period", 32'(period_c), 32'd15);
        check("w4a wrap step", 32'(fw_a), 32'd6);
        check("w4a period", 32'(period_a), 32'd6);

        nz_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
